ir_store_ctrl: RTL

Parametrised instruction store with a controlled load phase and a registered fetch phase. Replaces the single-mode, single-address instruction register file.
- Adds valid/ready streaming load with an auto-incrementing write pointer.
- Tracks the loaded word count.
- Provides a 1-cycle registered fetch port that flags out-of-range addresses.
- Sits between the program loader and the instruction decode stage of the small processor.

---
 rtl/ir_store_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/ir_store_ctrl.sv
// Instruction store: streaming valid/ready load phase with an auto-incrementing
// write pointer, followed by a run phase with a 1-cycle registered fetch port.
module ir_store_ctrl #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mode_load,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_ready,
    output logic                  ld_done,
    input  logic                  fetch_en,
    input  logic [ADDR_WIDTH-1:0] fetch_addr,
    output logic [DATA_WIDTH-1:0] fetch_data,
    output logic                  fetch_valid,
    output logic                  fetch_err,
    output logic [ADDR_WIDTH:0]   word_count,
    output logic                  busy_load
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_CNT = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   LAST_CNT  = (ADDR_WIDTH + 1)'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   CNT_ONE   = {{ADDR_WIDTH{1'b0}}, 1'b1};
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE   = {{(ADDR_WIDTH - 1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        FULL = 2'd2,
        RUN  = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [ADDR_WIDTH-1:0]   wr_ptr_reg, wr_ptr_next;
    logic [ADDR_WIDTH:0]     count_reg, count_next;
    logic                    ld_done_reg, ld_done_next;

    logic                    xfer;
    logic                    fetch_take;
    logic                    fetch_hit;

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [DATA_WIDTH-1:0]   rd_data_reg;
    logic                    blank_reg;
    logic                    fetch_valid_reg;
    logic                    fetch_err_reg;

    assign ld_ready   = (state_reg == LOAD) && (count_reg < DEPTH_CNT);
    assign xfer       = ld_ready && ld_valid;
    assign fetch_take = (state_reg == RUN) && fetch_en;
    assign fetch_hit  = ({1'b0, fetch_addr} < count_reg);

    always_comb begin
        state_next   = state_reg;
        wr_ptr_next  = wr_ptr_reg;
        count_next   = count_reg;
        ld_done_next = 1'b0;
        case (state_reg)
            IDLE: begin
                if (mode_load) begin
                    state_next  = LOAD;
                    wr_ptr_next = '0;
                    count_next  = '0;
                end else begin
                    state_next = RUN;
                end
            end
            LOAD: begin
                if (xfer) begin
                    wr_ptr_next = wr_ptr_reg + PTR_ONE;
                    count_next  = count_reg + CNT_ONE;
                end
                // Leaving on mode_load takes priority; either exit pulses ld_done once.
                if (!mode_load) begin
                    state_next   = RUN;
                    ld_done_next = 1'b1;
                end else if (xfer && (count_reg == LAST_CNT)) begin
                    state_next   = FULL;
                    ld_done_next = 1'b1;
                end
            end
            FULL: begin
                if (!mode_load) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (mode_load) begin
                    state_next  = LOAD;
                    wr_ptr_next = '0;
                    count_next  = '0;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            wr_ptr_reg  <= '0;
            count_reg   <= '0;
            ld_done_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            wr_ptr_reg  <= wr_ptr_next;
            count_reg   <= count_next;
            ld_done_reg <= ld_done_next;
        end
    end

    // Storage has no reset so it maps onto block RAM with a registered read.
    always_ff @(posedge clk) begin
        if (xfer && !rst) begin
            mem[wr_ptr_reg] <= ld_data;
        end
        if (fetch_take) begin
            rd_data_reg <= mem[fetch_addr];
        end
    end

    // blank_reg forces zero data after reset and for out-of-range fetches.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_valid_reg <= 1'b0;
            fetch_err_reg   <= 1'b0;
            blank_reg       <= 1'b1;
        end else begin
            fetch_valid_reg <= fetch_take;
            if (fetch_take) begin
                fetch_err_reg <= !fetch_hit;
                blank_reg     <= !fetch_hit;
            end
        end
    end

    assign fetch_data  = blank_reg ? '0 : rd_data_reg;
    assign fetch_valid = fetch_valid_reg;
    assign fetch_err   = fetch_err_reg;
    assign ld_done     = ld_done_reg;
    assign word_count  = count_reg;
    assign busy_load   = (state_reg == LOAD);

endmodule
